// File: rtl/ddr4_cmd_decoder.sv
// ddr4_cmd_decoder
//   Device-side DDR4 command decoder and per-bank state tracker.
//   Samples the command pins on every rising ck_t edge, decodes
//   ACT/RD/WR/PRE/PREA/REF, tracks each bank through
//   IDLE -> ACTIVATING -> ACTIVE -> PRECHARGING -> IDLE, and reports accepted
//   commands one cycle later. Illegal commands are dropped and flagged.
//
// Ports
//   ck_t, reset_n     clock, asynchronous active-low reset
//   cke, cs_n, act_n  clock enable, chip select, activate
//   A                 address; A16/A15/A14 = RAS_n/CAS_n/WE_n, A10 = AP/all
//   bg, ba            bank group / bank; bank index = {bg, ba}
//   sync              per-bank one-cycle pulse on an accepted ACT
//   bank_active       bank is ACTIVE
//   bank_idle         bank is IDLE
//   cmd_valid         one-cycle pulse, cmd_* hold an accepted command
//   cmd_code          0=ACT 1=RD 2=WR 3=PRE 4=PREA 5=REF
//   cmd_bank          target bank
//   cmd_row           row (ACT) or open row of the bank (RD/WR), else 0
//   cmd_col           column (RD/WR), else 0
//   err, err_code     sticky violation flag, code of the first violation
module ddr4_cmd_decoder #(
    parameter int unsigned BGWIDTH   = 2,
    parameter int unsigned BAWIDTH   = 2,
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned COLWIDTH  = 10,
    parameter int unsigned TRCD      = 4,
    parameter int unsigned TRP       = 4
) (
    input  logic                                  ck_t,
    input  logic                                  reset_n,
    input  logic                                  cke,
    input  logic                                  cs_n,
    input  logic                                  act_n,
    input  logic [ADDRWIDTH-1:0]                  A,
    input  logic [BGWIDTH-1:0]                    bg,
    input  logic [BAWIDTH-1:0]                    ba,
    output logic [2**(BGWIDTH+BAWIDTH)-1:0]       sync,
    output logic [2**(BGWIDTH+BAWIDTH)-1:0]       bank_active,
    output logic [2**(BGWIDTH+BAWIDTH)-1:0]       bank_idle,
    output logic                                  cmd_valid,
    output logic [2:0]                            cmd_code,
    output logic [BGWIDTH+BAWIDTH-1:0]            cmd_bank,
    output logic [ADDRWIDTH-1:0]                  cmd_row,
    output logic [COLWIDTH-1:0]                   cmd_col,
    output logic                                  err,
    output logic [2:0]                            err_code
);

    localparam int unsigned BW   = BGWIDTH + BAWIDTH;
    localparam int unsigned NB   = 2**BW;
    localparam int unsigned TMAX = (TRCD > TRP) ? TRCD : TRP;
    localparam int unsigned CW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE, S_ACTIVATING, S_ACTIVE, S_PRECHARGING
    } bank_state_t;

    typedef enum logic [2:0] {
        CMD_ACT  = 3'd0,
        CMD_RD   = 3'd1,
        CMD_WR   = 3'd2,
        CMD_PRE  = 3'd3,
        CMD_PREA = 3'd4,
        CMD_REF  = 3'd5,
        CMD_NOP  = 3'd7
    } cmd_t;

    bank_state_t          r_state     [NB];
    bank_state_t          w_state_nxt [NB];
    logic [CW-1:0]        r_cnt       [NB];
    logic [CW-1:0]        w_cnt_nxt   [NB];
    logic [ADDRWIDTH-1:0] r_row       [NB];
    logic [ADDRWIDTH-1:0] w_row_nxt   [NB];

    logic [NB-1:0]        r_sync;
    logic                 r_cmd_valid;
    logic [2:0]           r_cmd_code;
    logic [BW-1:0]        r_cmd_bank;
    logic [ADDRWIDTH-1:0] r_cmd_row;
    logic [COLWIDTH-1:0]  r_cmd_col;
    logic                 r_err;
    logic [2:0]           r_err_code;

    cmd_t                 w_cmd;
    logic [BW-1:0]        w_bank;
    bank_state_t          w_tgt;
    logic                 w_all_idle;
    logic                 w_accept;
    logic                 w_viol;
    logic [2:0]           w_viol_code;
    logic [NB-1:0]        w_sync_nxt;
    logic [ADDRWIDTH-1:0] w_row_out;
    logic [COLWIDTH-1:0]  w_col_out;

    assign w_bank = {bg, ba};
    assign w_tgt  = r_state[w_bank];

    // Pin decode; anything not recognised (MRS, ZQ, NOP, deselect) is a NOP.
    always_comb begin
        w_cmd = CMD_NOP;
        if (cke && !cs_n) begin
            if (!act_n) begin
                w_cmd = CMD_ACT;
            end else begin
                case (A[16:14])
                    3'b010:  w_cmd = A[10] ? CMD_PREA : CMD_PRE;
                    3'b101:  w_cmd = CMD_RD;
                    3'b100:  w_cmd = CMD_WR;
                    3'b001:  w_cmd = CMD_REF;
                    default: w_cmd = CMD_NOP;
                endcase
            end
        end
    end

    // Legality against the pre-edge bank state.
    always_comb begin
        w_all_idle  = 1'b1;
        for (int unsigned b = 0; b < NB; b++) begin
            if (r_state[b] != S_IDLE) w_all_idle = 1'b0;
        end
        w_accept    = 1'b0;
        w_viol      = 1'b0;
        w_viol_code = '0;
        case (w_cmd)
            CMD_ACT: begin
                if (w_tgt == S_IDLE) w_accept = 1'b1;
                else begin w_viol = 1'b1; w_viol_code = 3'd1; end
            end
            CMD_RD, CMD_WR: begin
                if (w_tgt == S_ACTIVE) w_accept = 1'b1;
                else begin w_viol = 1'b1; w_viol_code = 3'd2; end
            end
            CMD_PRE: begin
                // PRE to IDLE/PRECHARGING is a silent no-op.
                if (w_tgt == S_ACTIVE) w_accept = 1'b1;
                else if (w_tgt == S_ACTIVATING) begin
                    w_viol = 1'b1; w_viol_code = 3'd3;
                end
            end
            CMD_PREA: w_accept = 1'b1;
            CMD_REF: begin
                if (w_all_idle) w_accept = 1'b1;
                else begin w_viol = 1'b1; w_viol_code = 3'd4; end
            end
            default: ;
        endcase
    end

    // Per-bank next state: timer progression first, then the accepted command.
    always_comb begin
        for (int unsigned b = 0; b < NB; b++) begin
            w_state_nxt[b] = r_state[b];
            w_cnt_nxt[b]   = r_cnt[b];
            w_row_nxt[b]   = r_row[b];
            case (r_state[b])
                S_ACTIVATING: begin
                    if (r_cnt[b] == '0) w_state_nxt[b] = S_ACTIVE;
                    else                w_cnt_nxt[b]   = r_cnt[b] - CW'(1);
                end
                S_PRECHARGING: begin
                    if (r_cnt[b] == '0) w_state_nxt[b] = S_IDLE;
                    else                w_cnt_nxt[b]   = r_cnt[b] - CW'(1);
                end
                default: ;
            endcase
            if (w_accept) begin
                if (w_bank == BW'(b)) begin
                    case (w_cmd)
                        CMD_ACT: begin
                            w_state_nxt[b] = S_ACTIVATING;
                            w_cnt_nxt[b]   = CW'(TRCD - 1);
                            w_row_nxt[b]   = A;
                        end
                        CMD_RD, CMD_WR: begin
                            if (A[10]) begin
                                w_state_nxt[b] = S_PRECHARGING;
                                w_cnt_nxt[b]   = CW'(TRP - 1);
                            end
                        end
                        CMD_PRE: begin
                            w_state_nxt[b] = S_PRECHARGING;
                            w_cnt_nxt[b]   = CW'(TRP - 1);
                        end
                        default: ;
                    endcase
                end
                if (w_cmd == CMD_PREA && r_state[b] == S_ACTIVE) begin
                    w_state_nxt[b] = S_PRECHARGING;
                    w_cnt_nxt[b]   = CW'(TRP - 1);
                end
            end
        end
    end

    always_comb begin
        w_sync_nxt = '0;
        w_row_out  = '0;
        w_col_out  = '0;
        if (w_accept) begin
            case (w_cmd)
                CMD_ACT: begin
                    w_sync_nxt = NB'(1) << w_bank;
                    w_row_out  = A;
                end
                CMD_RD, CMD_WR: begin
                    w_row_out = r_row[w_bank];
                    w_col_out = A[COLWIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned b = 0; b < NB; b++) begin
                r_state[b] <= S_IDLE;
                r_cnt[b]   <= '0;
                r_row[b]   <= '0;
            end
            r_sync      <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= '0;
            r_cmd_bank  <= '0;
            r_cmd_row   <= '0;
            r_cmd_col   <= '0;
            r_err       <= 1'b0;
            r_err_code  <= '0;
        end else begin
            for (int unsigned b = 0; b < NB; b++) begin
                r_state[b] <= w_state_nxt[b];
                r_cnt[b]   <= w_cnt_nxt[b];
                r_row[b]   <= w_row_nxt[b];
            end
            r_sync      <= w_sync_nxt;
            r_cmd_valid <= w_accept;
            if (w_accept) begin
                r_cmd_code <= w_cmd;
                r_cmd_bank <= w_bank;
                r_cmd_row  <= w_row_out;
                r_cmd_col  <= w_col_out;
            end
            if (w_viol) begin
                r_err <= 1'b1;
                if (!r_err) r_err_code <= w_viol_code;
            end
        end
    end

    always_comb begin
        bank_active = '0;
        bank_idle   = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            bank_active[b] = (r_state[b] == S_ACTIVE);
            bank_idle[b]   = (r_state[b] == S_IDLE);
        end
    end

    assign sync      = r_sync;
    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign cmd_bank  = r_cmd_bank;
    assign cmd_row   = r_cmd_row;
    assign cmd_col   = r_cmd_col;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_ddr4_cmd_decoder.sv
// tb_ddr4_cmd_decoder
//   Directed scenarios plus randomized traffic against a timestamp-based bank
//   model: each bank remembers whether it was last opened or closed and on
//   which edge, and its state is derived from the elapsed edge count.
module tb_ddr4_cmd_decoder;

    localparam int TRCD = 4;
    localparam int TRP  = 4;

    localparam int K_ACT = 0, K_RD = 1, K_WR = 2, K_PRE = 3, K_PREA = 4,
                   K_REF = 5, K_DESEL = 6, K_CKEOFF = 7, K_OTHER = 8;

    logic        ck_t = 1'b0;
    logic        reset_n = 1'b0;
    logic        cke = 1'b0;
    logic        cs_n = 1'b1;
    logic        act_n = 1'b1;
    logic [16:0] A = '0;
    logic [1:0]  bg = '0;
    logic [1:0]  ba = '0;
    logic [15:0] sync, bank_active, bank_idle;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic [3:0]  cmd_bank;
    logic [16:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        err;
    logic [2:0]  err_code;

    ddr4_cmd_decoder #(
        .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17), .COLWIDTH(10),
        .TRCD(TRCD), .TRP(TRP)
    ) dut (
        .ck_t(ck_t), .reset_n(reset_n), .cke(cke), .cs_n(cs_n), .act_n(act_n),
        .A(A), .bg(bg), .ba(ba),
        .sync(sync), .bank_active(bank_active), .bank_idle(bank_idle),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .err(err), .err_code(err_code)
    );

    always #5 ck_t = ~ck_t;

    int edge_n = 0;
    always @(posedge ck_t) edge_n <= edge_n + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Bank model: open flag, edge of last ACT/close, latched row.
    bit          m_open [16];
    int          m_t    [16];
    logic [16:0] m_row  [16];
    bit          m_err;
    int          m_code;

    // 0 idle, 1 activating, 2 active, 3 precharging, as seen just before edge e.
    function automatic int st(input int b, input int e);
        if (m_open[b]) return (e - m_t[b] > TRCD) ? 2 : 1;
        else           return (e - m_t[b] > TRP)  ? 0 : 3;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 16; b++) begin
            m_open[b] = 1'b0;
            m_t[b]    = -1000;
            m_row[b]  = '0;
        end
        m_err  = 1'b0;
        m_code = 0;
    endtask

    task automatic check_reset_values();
        check_eq("rst_sync",     sync,        32'h0);
        check_eq("rst_active",   bank_active, 32'h0);
        check_eq("rst_idle",     bank_idle,   32'hFFFF);
        check_eq("rst_valid",    cmd_valid,   32'h0);
        check_eq("rst_code",     cmd_code,    32'h0);
        check_eq("rst_bank",     cmd_bank,    32'h0);
        check_eq("rst_row",      cmd_row,     32'h0);
        check_eq("rst_col",      cmd_col,     32'h0);
        check_eq("rst_err",      err,         32'h0);
        check_eq("rst_err_code", err_code,    32'h0);
    endtask

    // Called #1 after a rising edge: drives one command, predicts, checks.
    task automatic issue(input int kind, input int bank, input logic [16:0] addr, input bit ap);
        logic [16:0] a;
        logic [2:0]  oth [4];
        logic [15:0] esync, eact, eidl;
        logic [16:0] erow;
        logic [9:0]  ecol;
        int          e, s, ecode, vcode;
        bit          ev, busy;

        oth[0] = 3'b000; oth[1] = 3'b011; oth[2] = 3'b110; oth[3] = 3'b111;
        a = addr;
        cke = 1'b1; cs_n = 1'b0; act_n = 1'b1;
        bg = 2'(bank >> 2); ba = 2'(bank);
        case (kind)
            K_ACT:    act_n = 1'b0;
            K_RD:     begin a[16:14] = 3'b101; a[10] = ap; end
            K_WR:     begin a[16:14] = 3'b100; a[10] = ap; end
            K_PRE:    begin a[16:14] = 3'b010; a[10] = 1'b0; end
            K_PREA:   begin a[16:14] = 3'b010; a[10] = 1'b1; end
            K_REF:    a[16:14] = 3'b001;
            K_DESEL:  begin cs_n = 1'b1; act_n = 1'b0; end
            K_CKEOFF: begin cke = 1'b0; act_n = 1'b0; end
            default:  a[16:14] = oth[$urandom_range(0, 3)];
        endcase
        A = a;

        e = edge_n + 1;
        ev = 1'b0; esync = '0; erow = '0; ecol = '0; ecode = 0; vcode = 0;
        s = st(bank, e);
        case (kind)
            K_ACT: begin
                if (s == 0) begin
                    ev = 1'b1; ecode = 0; erow = a; esync[bank] = 1'b1;
                    m_open[bank] = 1'b1; m_t[bank] = e; m_row[bank] = a;
                end else vcode = 1;
            end
            K_RD, K_WR: begin
                if (s == 2) begin
                    ev = 1'b1; ecode = (kind == K_RD) ? 1 : 2;
                    erow = m_row[bank]; ecol = a[9:0];
                    if (ap) begin m_open[bank] = 1'b0; m_t[bank] = e; end
                end else vcode = 2;
            end
            K_PRE: begin
                if (s == 2) begin
                    ev = 1'b1; ecode = 3;
                    m_open[bank] = 1'b0; m_t[bank] = e;
                end else if (s == 1) vcode = 3;
            end
            K_PREA: begin
                ev = 1'b1; ecode = 4;
                for (int b = 0; b < 16; b++) begin
                    if (st(b, e) == 2) begin m_open[b] = 1'b0; m_t[b] = e; end
                end
            end
            K_REF: begin
                busy = 1'b0;
                for (int b = 0; b < 16; b++) if (st(b, e) != 0) busy = 1'b1;
                if (!busy) begin ev = 1'b1; ecode = 5; end
                else vcode = 4;
            end
            default: ;
        endcase
        if (vcode != 0 && !m_err) begin m_err = 1'b1; m_code = vcode; end
        else if (vcode != 0) m_err = 1'b1;

        eact = '0; eidl = '0;
        for (int b = 0; b < 16; b++) begin
            eact[b] = (st(b, e + 1) == 2);
            eidl[b] = (st(b, e + 1) == 0);
        end

        @(posedge ck_t);
        #1;
        check_eq("cmd_valid", cmd_valid, 32'(ev));
        if (ev) begin
            check_eq("cmd_code", cmd_code, 32'(ecode));
            check_eq("cmd_col",  cmd_col,  32'(ecol));
            if (kind != K_PREA && kind != K_REF)
                check_eq("cmd_bank", cmd_bank, 32'(bank));
            if (kind == K_ACT || kind == K_RD || kind == K_WR)
                check_eq("cmd_row", cmd_row, 32'(erow));
        end
        check_eq("sync",        sync,        32'(esync));
        check_eq("err",         err,         32'(m_err));
        check_eq("err_code",    err_code,    32'(m_code));
        check_eq("bank_active", bank_active, 32'(eact));
        check_eq("bank_idle",   bank_idle,   32'(eidl));
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(K_DESEL, 0, 17'(i), 1'b0);
    endtask

    // Called #1 after a rising edge; asserts reset mid-cycle for one edge.
    task automatic do_reset();
        #3;
        reset_n = 1'b0;
        cs_n = 1'b1; cke = 1'b0;
        #1;
        check_reset_values();
        @(posedge ck_t);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int k, bk, r;
        model_reset();
        #2;
        check_reset_values();
        repeat (2) @(posedge ck_t);
        #1;
        reset_n = 1'b1;

        // 16 back-to-back ACTs sweeping every bank.
        for (int i = 0; i < 16; i++) issue(K_ACT, i, 17'h1, 1'b0);
        nops(TRCD + 1);
        check_eq("all_active", bank_active, 32'hFFFF);
        do_reset();

        // ACT then RD with column.
        issue(K_ACT, 5, 17'h1ABCD, 1'b0);
        nops(TRCD);
        issue(K_RD, 5, 17'h0003F, 1'b0);
        check_eq("rd_row", cmd_row, 32'h1ABCD);

        // RD to idle bank, later ACT still accepted.
        issue(K_RD, 2, 17'h00011, 1'b0);
        issue(K_ACT, 3, 17'h00777, 1'b0);
        check_eq("err_code_kept", err_code, 32'd2);
        do_reset();

        // Double ACT to the same bank.
        issue(K_ACT, 0, 17'h00042, 1'b0);
        issue(K_ACT, 0, 17'h00043, 1'b0);
        do_reset();

        // Counter-expiry edge: RD on ACTIVATING->ACTIVE edge is illegal.
        issue(K_ACT, 1, 17'h00100, 1'b0);
        nops(TRCD - 1);
        issue(K_RD, 1, 17'h00005, 1'b0);
        do_reset();

        // PREA then REF.
        for (int i = 0; i < 4; i++) issue(K_ACT, i, 17'(i + 10), 1'b0);
        nops(TRCD + 1);
        issue(K_PREA, 0, 17'h0, 1'b0);
        nops(TRP + 1);
        check_eq("prea_idle", bank_idle[3:0], 32'hF);
        issue(K_REF, 0, 17'h0, 1'b0);
        check_eq("ref_err", err, 32'h0);

        // Auto-precharge, PRE to ACTIVATING, REF while busy.
        issue(K_ACT, 6, 17'h00ABC, 1'b0);
        issue(K_PRE, 6, 17'h0, 1'b0);
        nops(TRCD);
        issue(K_WR, 6, 17'h00155, 1'b1);
        issue(K_REF, 0, 17'h0, 1'b0);
        nops(TRP + 1);
        do_reset();

        // ACT aborted by reset before TRCD.
        issue(K_ACT, 7, 17'h00077, 1'b0);
        issue(K_DESEL, 0, 17'h0, 1'b0);
        do_reset();
        nops(TRCD + 2);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            bk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                             : int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 99));
            if      (r < 22) k = K_ACT;
            else if (r < 38) k = K_RD;
            else if (r < 52) k = K_WR;
            else if (r < 66) k = K_PRE;
            else if (r < 70) k = K_PREA;
            else if (r < 74) k = K_REF;
            else if (r < 86) k = K_DESEL;
            else if (r < 92) k = K_CKEOFF;
            else             k = K_OTHER;
            issue(k, bk, 17'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
